// File: rtl/cl_mcl_pkg.sv
// Shared manycore-link definitions: widths, packer FSM states, credit default
// and the bsg_mcl_request_s packet layout.
// Packet layout, LSB first: w0 = {src_y, src_x, y, x}, w1 = payload,
// w2 = {addr[15:0], op, op_ex}, w3 = {padding, addr[31:16]}.
// Because addr[15:0] sits at the top of w2 and addr[31:16] at the bottom of w3,
// the address forms one contiguous 32-bit field in the packed struct.
`ifndef CL_MCL_PKG_SV
`define CL_MCL_PKG_SV

`define DECLARE_BSG_MCL_REQUEST_S \
    typedef struct packed { \
        logic [15:0] padding; \
        logic [31:0] addr; \
        logic [7:0]  op; \
        logic [7:0]  op_ex; \
        logic [31:0] payload; \
        logic [7:0]  src_y; \
        logic [7:0]  src_x; \
        logic [7:0]  y; \
        logic [7:0]  x; \
    } bsg_mcl_request_s

package cl_mcl_pkg;

    localparam int axil_data_width_lp    = 32;
    localparam int mc_fifo_width_lp      = 128;
    localparam int mcl_req_words_lp      = mc_fifo_width_lp / axil_data_width_lp;
    localparam int mcl_default_credits_lp = 16;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        HOLD     = 1'b1
    } mcl_packer_state_e;

    `DECLARE_BSG_MCL_REQUEST_S;

endpackage

`endif

// File: rtl/mcl_credit_counter.sv
// Up/down credit counter that saturates at max_p. A return arriving while the
// counter is already full is dropped and latches err_o until reset.
// A simultaneous take and return cancel out, even at the limits.
module mcl_credit_counter #(
    parameter int max_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         dec_i,
    input  logic                         inc_i,
    output logic [$clog2(max_p+1)-1:0]   count_o,
    output logic                         err_o
);

    localparam int cw_lp = $clog2(max_p + 1);
    localparam logic [cw_lp-1:0] max_lp = cw_lp'(max_p);

    logic [cw_lp-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Next count and sticky overflow flag.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc_i && !dec_i) begin
            if (count_q == max_lp) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Counter registers; reset restores the full credit pool.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= max_lp;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mcl_host_req_packer.sv
// Packs four 32-bit host words into one 128-bit manycore request packet and
// releases it only while host request credits are available.
// Optional: define MCL_REQ_PACKER_STATS_EN to add the sent_count_o packet counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ASSEMBLE | accepting host words into the packet register
// HOLD     | packet complete; offered to the endpoint when credits != 0
module mcl_host_req_packer
    import cl_mcl_pkg::*;
#(
    parameter int data_width_p  = axil_data_width_lp,
    parameter int fifo_width_p  = mc_fifo_width_lp,
    parameter int max_credits_p = mcl_default_credits_lp
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [data_width_p-1:0]              in_data_i,
    input  logic                                 in_v_i,
    output logic                                 in_ready_o,
    output logic [fifo_width_p-1:0]              out_packet_o,
    output logic                                 out_v_o,
    input  logic                                 out_ready_i,
    input  logic                                 credit_return_i,
    output logic [$clog2(max_credits_p+1)-1:0]   credits_o,
`ifdef MCL_REQ_PACKER_STATS_EN
    output logic [31:0]                          sent_count_o,
`endif
    output logic                                 credit_err_o
);

    localparam int widx_w_lp = $clog2(mcl_req_words_lp);
    localparam logic [widx_w_lp-1:0] last_idx_lp = widx_w_lp'(mcl_req_words_lp - 1);

    mcl_packer_state_e       state_q, state_d;
    logic [widx_w_lp-1:0]    word_idx_q, word_idx_d;
    logic [fifo_width_p-1:0] pkt_q, pkt_d;
    logic                    transfer;
    bsg_mcl_request_s        req;

    // Next-state, packet capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        pkt_d      = pkt_q;
        in_ready_o = 1'b0;
        out_v_o    = 1'b0;
        transfer   = 1'b0;
        case (state_q)
            ASSEMBLE: begin
                in_ready_o = 1'b1;
                if (in_v_i) begin
                    for (int k = 0; k < mcl_req_words_lp; k++) begin
                        if (word_idx_q == k[widx_w_lp-1:0]) begin
                            pkt_d[k*data_width_p +: data_width_p] = in_data_i;
                        end
                    end
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == last_idx_lp) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_v_o  = (credits_o != '0);
                transfer = out_v_o && out_ready_i;
                if (transfer) begin
                    state_d = ASSEMBLE;
                end
            end
            default: state_d = ASSEMBLE;
        endcase
    end

    // FSM, word index and packet registers; reset drops any partial packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ASSEMBLE;
            word_idx_q <= '0;
            pkt_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            pkt_q      <= pkt_d;
        end
    end

    assign req          = pkt_q;
    assign out_packet_o = req;

    mcl_credit_counter #(
        .max_p (max_credits_p)
    ) u_credits (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .dec_i     (transfer),
        .inc_i     (credit_return_i),
        .count_o   (credits_o),
        .err_o     (credit_err_o)
    );

`ifdef MCL_REQ_PACKER_STATS_EN
    logic [31:0] sent_q, sent_d;

    // Free-running count of transferred packets, wraps naturally.
    always_comb begin
        sent_d = sent_q;
        if (transfer) begin
            sent_d = sent_q + 32'd1;
        end
    end

    // Sent-packet counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

    assign sent_count_o = sent_q;
`endif

endmodule
